// File: rtl/comparator_bist_pkg.sv
// Shared types, constants and the comparator reference model for the BIST engine.
package comparator_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } bist_state_e;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 in a left-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] IDX_NONE  = 16'hFFFF;

    // Expected cascadable-comparator outputs, returned as {lt, et, gt}
    function automatic logic [2:0] cmp_expected(input logic [7:0] a, input logic [7:0] b,
                                                input logic l, input logic e, input logic g);
        logic lt, et, gt;
        gt = (a > b) | ((a == b) & g);
        lt = (a < b) | ((a == b) & l);
        et = (a == b) & e;
        return {lt, et, gt};
    endfunction

endpackage

// File: rtl/comparator_bist_if.sv
// Stimulus/response bundle between the BIST engine and the comparator under test.
interface comparator_bist_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] dut_a;
    logic [WIDTH-1:0] dut_b;
    logic             dut_l;
    logic             dut_e;
    logic             dut_g;
    logic             dut_lt;
    logic             dut_et;
    logic             dut_gt;

    // BIST side: drives operands and cascade inputs, observes results
    modport master (
        output dut_a, dut_b, dut_l, dut_e, dut_g,
        input  dut_lt, dut_et, dut_gt
    );

    // Comparator side
    modport slave (
        input  dut_a, dut_b, dut_l, dut_e, dut_g,
        output dut_lt, dut_et, dut_gt
    );
endinterface

// File: rtl/comparator_bist_lfsr.sv
// 16-bit Fibonacci LFSR, shifting left with the feedback bit entering at bit 0.
module bist_lfsr16
    import comparator_bist_pkg::*;
#(
    parameter logic [15:0] RESET_VAL = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [15:0] seed,
    output logic [15:0] state
);

    // Load has priority so a restart always begins from the seed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    state <= RESET_VAL;
        else if (load) state <= seed;
        else if (step) state <= {state[14:0], ^(state & LFSR_TAPS)};
    end

endmodule

// File: rtl/comparator_bist.sv
// BIST engine: applies LFSR vectors to a cascadable comparator, checks and logs errors.
module comparator_bist
    import comparator_bist_pkg::*;
#(
    parameter int          WIDTH         = 8,
    parameter int          NUM_VECTORS   = 256,
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    comparator_bist_if.master  dut_if,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [15:0]        err_count,
    output logic [15:0]        first_fail_idx
);

    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [15:0] LAST_IDX    = 16'(NUM_VECTORS - 1);

    bist_state_e      state;
    logic [15:0]      k;
    logic [3:0]       settle_cnt;
    logic [15:0]      lfsr;
    logic             lfsr_load, lfsr_step;
    logic [WIDTH-1:0] vec_a, vec_b;
    logic [2:0]       exp_res;
    logic             mismatch;

    // Seed on every accepted start; advance once per checked vector
    assign lfsr_load = (state == S_IDLE || state == S_DONE) && start && !abort;
    assign lfsr_step = (state == S_CHECK) && !abort;

    bist_lfsr16 #(.RESET_VAL(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .seed  (LFSR_SEED),
        .state (lfsr)
    );

    // Vector k: A from the low bits, B from the high bits, forced equal when k[3:2]==2'b11
    always_comb begin
        vec_a = lfsr[WIDTH-1:0];
        vec_b = (k[3:2] == 2'b11) ? lfsr[WIDTH-1:0] : lfsr[15 -: WIDTH];
    end

    // Reference model against the currently held drive values
    always_comb begin
        exp_res  = cmp_expected(8'(dut_if.dut_a), 8'(dut_if.dut_b),
                                dut_if.dut_l, dut_if.dut_e, dut_if.dut_g);
        mismatch = ({dut_if.dut_lt, dut_if.dut_et, dut_if.dut_gt} != exp_res);
    end

    assign pass = done && (err_count == 16'h0000);

    // Run sequencer; abort overrides everything but keeps the error log
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            k              <= '0;
            settle_cnt     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            first_fail_idx <= IDX_NONE;
            dut_if.dut_a   <= '0;
            dut_if.dut_b   <= '0;
            dut_if.dut_l   <= 1'b0;
            dut_if.dut_e   <= 1'b0;
            dut_if.dut_g   <= 1'b0;
        end else if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_APPLY;
                        k              <= '0;
                        err_count      <= '0;
                        first_fail_idx <= IDX_NONE;
                        done           <= 1'b0;
                        busy           <= 1'b1;
                    end
                end
                S_APPLY: begin
                    dut_if.dut_a <= vec_a;
                    dut_if.dut_b <= vec_b;
                    dut_if.dut_l <= k[2];
                    dut_if.dut_e <= k[1];
                    dut_if.dut_g <= k[0];
                    settle_cnt   <= SETTLE_LOAD;
                    state        <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == 4'd0) state <= S_CHECK;
                    else                    settle_cnt <= settle_cnt - 4'd1;
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (err_count != 16'hFFFF)      err_count      <= err_count + 16'd1;
                        if (first_fail_idx == IDX_NONE) first_fail_idx <= k;
                    end
                    k <= k + 16'd1;
                    if (k == LAST_IDX) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= S_APPLY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_comparator_bist.sv
// Directed bench: default-size BIST against a fault-injectable comparator, plus a 1-vector instance.
module tb_comparator_bist;
    import comparator_bist_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, abort = 1'b0, start2 = 1'b0;
    logic        gt_stuck0 = 1'b0, et_stuck0 = 1'b0;
    logic        busy, done, pass, busy2, done2, pass2;
    logic [15:0] err_count, first_fail_idx, err_count2, first_fail_idx2;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    comparator_bist_if #(.WIDTH(8)) cif  ();
    comparator_bist_if #(.WIDTH(8)) cif2 ();

    // Behavioural comparator under test, with stuck-at-0 fault controls
    assign cif.dut_gt  = ~gt_stuck0 & ((cif.dut_a > cif.dut_b) | ((cif.dut_a == cif.dut_b) & cif.dut_g));
    assign cif.dut_lt  = (cif.dut_a < cif.dut_b) | ((cif.dut_a == cif.dut_b) & cif.dut_l);
    assign cif.dut_et  = ~et_stuck0 & (cif.dut_a == cif.dut_b) & cif.dut_e;
    assign cif2.dut_gt = (cif2.dut_a > cif2.dut_b) | ((cif2.dut_a == cif2.dut_b) & cif2.dut_g);
    assign cif2.dut_lt = (cif2.dut_a < cif2.dut_b) | ((cif2.dut_a == cif2.dut_b) & cif2.dut_l);
    assign cif2.dut_et = (cif2.dut_a == cif2.dut_b) & cif2.dut_e;

    comparator_bist u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_if(cif),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_idx(first_fail_idx)
    );

    comparator_bist #(.NUM_VECTORS(1), .SETTLE_CYCLES(1)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(1'b0), .dut_if(cif2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err_count2), .first_fail_idx(first_fail_idx2)
    );

    // Scoreboard: replay the 256-vector run with the given faults, count miscompares
    function automatic int model_errs(input bit gt_f, input bit et_f);
        logic [15:0] lf = 16'hACE1;
        logic [15:0] kk;
        logic [7:0]  a, b;
        logic [2:0]  e, o;
        int          n = 0;
        for (int i = 0; i < 256; i++) begin
            kk = 16'(i);
            a  = lf[7:0];
            b  = (kk[3:2] == 2'b11) ? lf[7:0] : lf[15:8];
            e  = cmp_expected(a, b, kk[2], kk[1], kk[0]);
            o  = e & ~{1'b0, et_f, gt_f};
            if (o != e) n++;
            lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
        end
        return n;
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Cycles from the accepting edge until done is first seen, bounded
    task automatic run_to_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 5000) begin
            @(posedge clk); #1 cyc++;
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL done_timeout: done never rose within %0d cycles", cyc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0)            begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0)            begin miscompares++; $display("FAIL rst_done: got %b want 0", done); end
        vectors++; if (pass !== 1'b0)            begin miscompares++; $display("FAIL rst_pass: got %b want 0", pass); end
        vectors++; if (err_count !== 16'h0)      begin miscompares++; $display("FAIL rst_err: got %h want 0", err_count); end
        vectors++; if (first_fail_idx !== 16'hFFFF) begin miscompares++; $display("FAIL rst_ffi: got %h want ffff", first_fail_idx); end
        vectors++; if ({cif.dut_a, cif.dut_b, cif.dut_l, cif.dut_e, cif.dut_g} !== 19'h0)
            begin miscompares++; $display("FAIL rst_drive: got a=%h b=%h lge=%b want all 0", cif.dut_a, cif.dut_b, {cif.dut_l, cif.dut_e, cif.dut_g}); end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_run();
        int cyc;
        pulse_start();
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL clean_busy: got %b want 1", busy); end
        run_to_done(cyc);
        vectors++; if (cyc != 1024)              begin miscompares++; $display("FAIL clean_latency: got %0d want 1024", cyc); end
        vectors++; if (pass !== 1'b1)            begin miscompares++; $display("FAIL clean_pass: got %b want 1", pass); end
        vectors++; if (err_count !== 16'h0)      begin miscompares++; $display("FAIL clean_err: got %h want 0", err_count); end
        vectors++; if (first_fail_idx !== 16'hFFFF) begin miscompares++; $display("FAIL clean_ffi: got %h want ffff", first_fail_idx); end
    endtask

    task automatic test_fault(input bit gt_f, input bit et_f, input logic [15:0] want_ffi);
        int cyc;
        int want_err;
        want_err  = model_errs(gt_f, et_f);
        gt_stuck0 = gt_f;
        et_stuck0 = et_f;
        pulse_start();
        run_to_done(cyc);
        vectors++; if (first_fail_idx !== want_ffi) begin miscompares++; $display("FAIL fault_ffi: got %0d want %0d", first_fail_idx, want_ffi); end
        vectors++; if (err_count !== 16'(want_err)) begin miscompares++; $display("FAIL fault_err: got %0d want %0d", err_count, want_err); end
        vectors++; if (pass !== 1'b0)              begin miscompares++; $display("FAIL fault_pass: got %b want 0", pass); end
        gt_stuck0 = 1'b0;
        et_stuck0 = 1'b0;
    endtask

    task automatic test_abort();
        int cyc;
        pulse_start();
        repeat (499) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %b want 0", done); end
        repeat (10) @(posedge clk);
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle: got busy %b want 0", busy); end
        pulse_start();
        run_to_done(cyc);
        vectors++; if (cyc != 1024 || pass !== 1'b1 || err_count !== 16'h0 || first_fail_idx !== 16'hFFFF)
            begin miscompares++; $display("FAIL abort_rerun: got lat=%0d pass=%b err=%h ffi=%h want 1024 1 0 ffff", cyc, pass, err_count, first_fail_idx); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        // start from DONE is accepted and clears done on the accepting edge
        pulse_start();
        vectors++; if (done !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL restart_flags: got done=%b busy=%b want 0 1", done, busy); end
        repeat (99) @(posedge clk);
        // start while busy must not disturb the run
        #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 100;
        while (!done && cyc < 5000) begin
            @(posedge clk); #1 cyc++;
        end
        vectors++; if (cyc != 1024) begin miscompares++; $display("FAIL busy_start_latency: got %0d want 1024", cyc); end
    endtask

    task automatic test_reset_midrun();
        bit seen_done = 1'b0;
        pulse_start();
        repeat (299) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL async_rst_busy: got %b want 0", busy); end
        vectors++; if (cif.dut_a !== 8'h00 || cif.dut_b !== 8'h00)
            begin miscompares++; $display("FAIL async_rst_drive: got a=%h b=%h want 00 00", cif.dut_a, cif.dut_b); end
        vectors++; if (first_fail_idx !== 16'hFFFF) begin miscompares++; $display("FAIL async_rst_ffi: got %h want ffff", first_fail_idx); end
        @(posedge clk); #1 rst_n = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            @(posedge clk); #1;
            if (done) seen_done = 1'b1;
        end
        vectors++; if (seen_done || busy !== 1'b0) begin miscompares++; $display("FAIL rst_discard: got done_seen=%b busy=%b want 0 0", seen_done, busy); end
    endtask

    task automatic test_single_vector();
        int cyc = 0;
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        while (!done2 && cyc < 50) begin
            @(posedge clk); #1 cyc++;
        end
        vectors++; if (cyc != 3) begin miscompares++; $display("FAIL small_latency: got %0d want 3", cyc); end
        vectors++; if (cif2.dut_a !== 8'hE1 || cif2.dut_b !== 8'hAC)
            begin miscompares++; $display("FAIL small_vector: got a=%h b=%h want e1 ac", cif2.dut_a, cif2.dut_b); end
        vectors++; if (pass2 !== 1'b1 || first_fail_idx2 !== 16'hFFFF)
            begin miscompares++; $display("FAIL small_pass: got pass=%b ffi=%h want 1 ffff", pass2, first_fail_idx2); end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_fault(1'b1, 1'b0, 16'd0);
        test_fault(1'b0, 1'b1, 16'd14);
        test_abort();
        test_back_to_back();
        test_reset_midrun();
        test_single_vector();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
